funct_generator_seq_ctrl: RTL and testbench
===========================================

# funct_generator_seq_ctrl

Sequencer for the function generator's waveform select mux. It steps `sel_o`/`enh_o` through a programmable table of (select, dwell) slots, so the generator emits a timed sequence of waveforms into the generator FIFO. It pauses on FIFO backpressure, and can run once or loop.

## Interface
- `SLOTS`, 4: number of program slots, power of 2, ≥2; `AW = $clog2(SLOTS)`.
- `CNT_WIDTH`, 16: width of dwell counter and dwell field.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start_i`  in  1  start request, sampled in IDLE only.
- `stop_i`  in  1  abort request.
- `loop_i`  in  1  loop mode request, latched at start.
- `fifo_full_i`  in  1  generator FIFO full; pauses sequencing.
- `cfg_we_i`  in  1  table write strobe.
- `cfg_addr_i`  in  AW  slot index to write.
- `cfg_sel_i`  in  2  mux select for the slot.
- `cfg_dwell_i`  in  CNT_WIDTH  enabled cycles for the slot.
- `cfg_last_i`  in  AW  index of the last active slot, latched at start.
- `sel_o`  out  2  mux select to `funct_generator_mux`.
- `enh_o`  out  1  mux enable.
- `slot_o`  out  AW  current slot index.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  1-cycle pulse when a single-shot sequence completes.
- `cfg_err_o`  out  1  1-cycle pulse when a write is rejected.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values:
  - all outputs 0;
  - table slots sel=0, dwell=1;
  - latched last=0, latched loop=0.
- IDLE → RUN on `start_i && !stop_i`:
  - latch `cfg_last_i` and `loop_i`;
  - slot=0;
  - counter=max(dwell[0],1).
- `stop_i` has priority over `start_i` in every state.
- RUN:
  - `sel_o = table[slot].sel`, `slot_o = slot`, `busy_o = 1`.
  - `enh_o = !fifo_full_i`, combinational from the registered state.
  - The counter decrements only on cycles with `enh_o = 1`.
  - On an enabled cycle with counter==1, advance:
    - slot<last: slot+1, counter reloaded with max(dwell,1);
    - slot==last and loop active: slot 0, reload;
    - slot==last, otherwise: go to DONE.
- `stop_i` in RUN: go to IDLE next cycle; no `done_o`; the current output cycle still completes normally.
- DONE: `done_o = 1`, `enh_o = 0`, `sel_o = 0`; go to IDLE next cycle. `start_i` is ignored in DONE.
- IDLE/DONE: `sel_o = 0`, `enh_o = 0`, `slot_o = 0`. This keeps the mux output 0 while not enabled.
- Table writes:
  - accepted only in IDLE;
  - a write in RUN or DONE is dropped and `cfg_err_o` pulses the next cycle;
  - a write in the same cycle as an accepted start is dropped with `cfg_err_o`.
- Dwell 0 is treated as 1. Slots above the latched last are never visited.
- `start_i` in RUN is ignored without error.

## Timing
- `start_i` sampled at edge N → RUN from cycle N+1; the first enabled cycle is N+1 if not full.
- `fifo_full_i` → `enh_o` is zero-latency (combinational). `sel_o` and the counter hold while full.
- Single-shot with no backpressure: Σ max(dwell,1) enabled cycles, then DONE for 1 cycle, then IDLE.
- Advancing between slots inserts no bubble; the new `sel_o` appears the cycle after the last enabled cycle of the previous slot.
- `rst_n` low mid-RUN: IDLE and reset values on the next edge. The table is reinitialised.

## Configuration
- `GEN_SEQ_LOOP_EN`:
  - Defined: the latched `loop_i` enables wrap from last to slot 0. The sequence runs until `stop_i`, and `done_o` never pulses in loop mode.
  - Undefined: `loop_i` is ignored (latched loop is constant 0) and every run is single-shot.

## Test plan
- Slots 0..2 = (sel 1, dwell 2), (sel 2, dwell 3), (sel 3, dwell 1); last=2; `start_i` at cycle 0 → `enh_o` cycles 1–6, `sel_o` = 1,1,2,2,2,3, `done_o` at cycle 7, IDLE at 8.
- Same program, `fifo_full_i` high in cycle 2 → `enh_o` low in cycle 2 with `sel_o` = 1; sequence ends cycle 7; `done_o` at cycle 8.
- Slot 0 dwell=0, last=0 → exactly 1 enabled cycle, `done_o` next cycle.
- `cfg_we_i` in RUN → table unchanged, `cfg_err_o` pulses once; `start_i` and `stop_i` together in IDLE → stays IDLE.
- With `GEN_SEQ_LOOP_EN`, `loop_i` = 1, last=1, dwells 1,1 → `sel_o` alternates slot0/slot1 indefinitely; `stop_i` → IDLE next cycle, no `done_o`.
- `rst_n` low during slot 1 → next cycle all outputs 0, IDLE; a new start replays the default table (sel 0, dwell 1).

Source files
------------

// File: rtl/funct_generator_seq_ctrl_if.sv
// Control/status bundle between the function generator sequencer and its driver.
// master drives requests and table writes, slave is the sequencer.
interface funct_generator_seq_ctrl_if #(
  parameter int SLOTS     = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int AW = $clog2(SLOTS);

  logic                 start_i;
  logic                 stop_i;
  logic                 loop_i;
  logic                 fifo_full_i;
  logic                 cfg_we_i;
  logic [AW-1:0]        cfg_addr_i;
  logic [1:0]           cfg_sel_i;
  logic [CNT_WIDTH-1:0] cfg_dwell_i;
  logic [AW-1:0]        cfg_last_i;
  logic [1:0]           sel_o;
  logic                 enh_o;
  logic [AW-1:0]        slot_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 cfg_err_o;

  modport master (
    output start_i, stop_i, loop_i, fifo_full_i, cfg_we_i,
           cfg_addr_i, cfg_sel_i, cfg_dwell_i, cfg_last_i,
    input  sel_o, enh_o, slot_o, busy_o, done_o, cfg_err_o
  );

  modport slave (
    input  start_i, stop_i, loop_i, fifo_full_i, cfg_we_i,
           cfg_addr_i, cfg_sel_i, cfg_dwell_i, cfg_last_i,
    output sel_o, enh_o, slot_o, busy_o, done_o, cfg_err_o
  );
endinterface

// File: rtl/funct_generator_seq_ctrl.sv
// Steps the waveform mux through a (select, dwell) slot table, pausing on FIFO full.
// Define GEN_SEQ_LOOP_EN to let the latched loop_i wrap from the last slot back to slot 0.
module funct_generator_seq_ctrl #(
  parameter int SLOTS     = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  funct_generator_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_tbl_sel   [SLOTS];
  logic [CNT_WIDTH-1:0] r_tbl_dwell [SLOTS];
  logic [AW-1:0]        r_slot;
  logic [AW-1:0]        r_last;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_sel;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_start;
  logic                 w_wr_accept;
  logic                 w_loop_active;
  logic [AW-1:0]        w_next_slot;

  function automatic logic [CNT_WIDTH-1:0] f_dwell_eff(input logic [CNT_WIDTH-1:0] d);
    return (d == '0) ? CNT_WIDTH'(1) : d;
  endfunction

  assign w_start     = bus.start_i && !bus.stop_i;
  // A write racing an accepted start would change the program under the run, so it is refused.
  assign w_wr_accept = bus.cfg_we_i && (r_state == IDLE) && !w_start;
  assign w_next_slot = (r_slot < r_last) ? r_slot + AW'(1) : '0;

`ifdef GEN_SEQ_LOOP_EN
  logic r_loop;
  assign w_loop_active = r_loop;
`else
  logic w_unused_loop;
  assign w_loop_active = 1'b0;
  assign w_unused_loop = bus.loop_i;
`endif

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_tbl_sel[gi]   <= 2'd0;
          r_tbl_dwell[gi] <= CNT_WIDTH'(1);
        end else if (w_wr_accept && (bus.cfg_addr_i == AW'(gi))) begin
          r_tbl_sel[gi]   <= bus.cfg_sel_i;
          r_tbl_dwell[gi] <= bus.cfg_dwell_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef GEN_SEQ_LOOP_EN
      r_loop  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= bus.cfg_we_i && !w_wr_accept;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_slot  <= '0;
            r_sel   <= r_tbl_sel[0];
            r_cnt   <= f_dwell_eff(r_tbl_dwell[0]);
            r_last  <= bus.cfg_last_i;
`ifdef GEN_SEQ_LOOP_EN
            r_loop  <= bus.loop_i;
`endif
          end
        end
        RUN: begin
          if (bus.stop_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sel   <= 2'd0;
            r_slot  <= '0;
          end else if (!bus.fifo_full_i) begin
            // The counter only burns cycles the mux is actually enabled.
            if (r_cnt == CNT_WIDTH'(1)) begin
              if ((r_slot < r_last) || w_loop_active) begin
                r_slot <= w_next_slot;
                r_sel  <= r_tbl_sel[w_next_slot];
                r_cnt  <= f_dwell_eff(r_tbl_dwell[w_next_slot]);
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_sel   <= 2'd0;
                r_slot  <= '0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel_o     = r_sel;
  assign bus.enh_o     = r_busy && !bus.fifo_full_i;
  assign bus.slot_o    = r_slot;
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.cfg_err_o = r_err;
endmodule

// File: tb/tb_funct_generator_seq_ctrl.sv
// Cycle-by-cycle bench for funct_generator_seq_ctrl: one vector per clock, outputs
// packed as {sel, enh, slot, busy, done, err} and checked through a scoreboard queue.
module tb_funct_generator_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  funct_generator_seq_ctrl_if #(.SLOTS(4), .CNT_WIDTH(16)) bus ();

  funct_generator_seq_ctrl #(.SLOTS(4), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop;
    logic        full;
    logic        we;
    logic [1:0]  addr;
    logic [1:0]  csel;
    logic [15:0] dwell;
    logic [1:0]  last;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [7:0] Z = 8'h00;

  function automatic logic [7:0] E(int sel, bit enh, int slot, bit busy, bit done, bit err);
    return {2'(sel), enh, 2'(slot), busy, done, err};
  endfunction

  function automatic logic [7:0] R(int sel, int slot);
    return E(sel, 1'b1, slot, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [7:0] D();
    return E(0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic vec_t V(string n, bit st, bit sp, bit full, bit we,
                             int addr, int cs, int dw, int last, logic [7:0] e);
    vec_t v;
    v.name  = n;
    v.rst_n = 1'b1;
    v.start = st;
    v.stop  = sp;
    v.loop  = 1'b0;
    v.full  = full;
    v.we    = we;
    v.addr  = 2'(addr);
    v.csel  = 2'(cs);
    v.dwell = 16'(dw);
    v.last  = 2'(last);
    v.exp   = e;
    return v;
  endfunction

  function automatic void add(vec_t v);
    vecs.push_back(v);
  endfunction

  // Program (1,2),(2,3),(3,1), last=2: enh cycles 1-6, sel 1,1,2,2,2,3, done at 7.
  function automatic void add_plan1(string p);
    add(V({p, "_start"}, 1, 0, 0, 0, 0, 0, 0, 2, Z));
    for (int i = 0; i < 2; i++) add(V({p, "_s0"}, 0, 0, 0, 0, 0, 0, 0, 0, R(1, 0)));
    for (int i = 0; i < 3; i++) add(V({p, "_s1"}, 0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    add(V({p, "_s2"},   0, 0, 0, 0, 0, 0, 0, 0, R(3, 2)));
    add(V({p, "_done"}, 0, 0, 0, 0, 0, 0, 0, 0, D()));
    add(V({p, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0, Z));
  endfunction

  task automatic step(input vec_t v);
    vec_t       e;
    logic [7:0] got;
    rst_n           = v.rst_n;
    bus.start_i     = v.start;
    bus.stop_i      = v.stop;
    bus.loop_i      = v.loop;
    bus.fifo_full_i = v.full;
    bus.cfg_we_i    = v.we;
    bus.cfg_addr_i  = v.addr;
    bus.cfg_sel_i   = v.csel;
    bus.cfg_dwell_i = v.dwell;
    bus.cfg_last_i  = v.last;
    sb.push_back(v);
    @(negedge clk);
    e   = sb.pop_front();
    got = {bus.sel_o, bus.enh_o, bus.slot_o, bus.busy_o, bus.done_o, bus.cfg_err_o};
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (sel,enh,slot,busy,done,err)", e.name, got, e.exp);
    end else begin
      $display("[TB] %-12s out=%b", e.name, got);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.loop_i      = 1'b0;
    bus.fifo_full_i = 1'b0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = '0;
    bus.cfg_sel_i   = '0;
    bus.cfg_dwell_i = '0;
    bus.cfg_last_i  = '0;
    @(posedge clk);
    #1;

    // Reset state, with a start request that must be ignored while in reset.
    v = V("rst0", 1, 0, 0, 0, 0, 0, 0, 0, Z); v.rst_n = 1'b0; add(v);
    v = V("rst1", 0, 0, 0, 0, 0, 0, 0, 0, Z); v.rst_n = 1'b0; add(v);
    add(V("idle0", 0, 0, 0, 0, 0, 0, 0, 0, Z));
    // Program slots; slot 3 is never visited with last=2.
    add(V("wr0", 0, 0, 0, 1, 0, 1, 2, 0, Z));
    add(V("wr1", 0, 0, 0, 1, 1, 2, 3, 0, Z));
    add(V("wr2", 0, 0, 0, 1, 2, 3, 1, 0, Z));
    add(V("wr3", 0, 0, 0, 1, 3, 2, 7, 0, Z));
    add_plan1("p1");
    // Backpressure in cycle 2 stretches the run by one cycle.
    add(V("bp_start", 1, 0, 0, 0, 0, 0, 0, 2, Z));
    add(V("bp_c1",    0, 0, 0, 0, 0, 0, 0, 0, R(1, 0)));
    add(V("bp_full",  0, 0, 1, 0, 0, 0, 0, 0, E(1, 0, 0, 1, 0, 0)));
    add(V("bp_c3",    0, 0, 0, 0, 0, 0, 0, 0, R(1, 0)));
    for (int i = 0; i < 3; i++) add(V("bp_s1", 0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    add(V("bp_s2",    0, 0, 0, 0, 0, 0, 0, 0, R(3, 2)));
    add(V("bp_done",  0, 0, 0, 0, 0, 0, 0, 0, D()));
    add(V("bp_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));
    // Writes in RUN and DONE are rejected; start in RUN is ignored.
    add(V("we_start", 1, 0, 0, 0, 0, 0, 0, 2, Z));
    add(V("we_run",   0, 0, 0, 1, 0, 0, 5, 0, R(1, 0)));
    add(V("we_err",   0, 0, 0, 0, 0, 0, 0, 0, E(1, 1, 0, 1, 0, 1)));
    add(V("st_run",   1, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    for (int i = 0; i < 2; i++) add(V("we_s1", 0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    add(V("we_s2",    0, 0, 0, 0, 0, 0, 0, 0, R(3, 2)));
    add(V("we_done",  0, 0, 0, 1, 1, 0, 1, 0, D()));
    add(V("we_derr",  0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 1)));
    add(V("we_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));
    // Start with stop stays idle; start with write drops the write; stop aborts.
    add(V("ss_both",  1, 1, 0, 0, 0, 0, 0, 2, Z));
    add(V("ss_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));
    add(V("sw_start", 1, 0, 0, 1, 2, 0, 9, 2, Z));
    add(V("sw_err",   0, 0, 0, 0, 0, 0, 0, 0, E(1, 1, 0, 1, 0, 1)));
    add(V("sp_stop",  0, 1, 0, 0, 0, 0, 0, 0, R(1, 0)));
    add(V("sp_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));
    add(V("sp_idle2", 0, 0, 0, 0, 0, 0, 0, 0, Z));
    add_plan1("p1b");
    // Dwell 0 behaves as dwell 1.
    add(V("d0_wr",    0, 0, 0, 1, 0, 2, 0, 0, Z));
    add(V("d0_start", 1, 0, 0, 0, 0, 0, 0, 0, Z));
    add(V("d0_run",   0, 0, 0, 0, 0, 0, 0, 0, R(2, 0)));
    add(V("d0_done",  0, 0, 0, 0, 0, 0, 0, 0, D()));
    add(V("d0_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Loop request with last=1, dwells 1,1.
    step(V("lp_wr0", 0, 0, 0, 1, 0, 1, 1, 0, Z));
    step(V("lp_wr1", 0, 0, 0, 1, 1, 2, 1, 0, Z));
    v = V("lp_start", 1, 0, 0, 0, 0, 0, 0, 1, Z); v.loop = 1'b1; step(v);
`ifdef GEN_SEQ_LOOP_EN
    for (int i = 0; i < 6; i++) step(V("lp_run", 0, 0, 0, 0, 0, 0, 0, 0, R(1 + (i % 2), i % 2)));
    step(V("lp_stop",  0, 1, 0, 0, 0, 0, 0, 0, R(1, 0)));
    step(V("lp_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));
    step(V("lp_idle2", 0, 0, 0, 0, 0, 0, 0, 0, Z));
`else
    step(V("lp_s0",   0, 0, 0, 0, 0, 0, 0, 0, R(1, 0)));
    step(V("lp_s1",   0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    step(V("lp_done", 0, 0, 0, 0, 0, 0, 0, 0, D()));
    step(V("lp_idle", 0, 0, 0, 0, 0, 0, 0, 0, Z));
`endif

    // Reset during slot 1 reinitialises the table to (sel 0, dwell 1).
    step(V("rr_wr1",   0, 0, 0, 1, 1, 2, 4, 0, Z));
    step(V("rr_start", 1, 0, 0, 0, 0, 0, 0, 1, Z));
    step(V("rr_s0",    0, 0, 0, 0, 0, 0, 0, 0, R(1, 0)));
    step(V("rr_s1",    0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)));
    v = V("rr_rst", 0, 0, 0, 0, 0, 0, 0, 0, R(2, 1)); v.rst_n = 1'b0; step(v);
    step(V("rr_start2", 1, 0, 0, 0, 0, 0, 0, 1, Z));
    step(V("rr_def0",  0, 0, 0, 0, 0, 0, 0, 0, R(0, 0)));
    step(V("rr_def1",  0, 0, 0, 0, 0, 0, 0, 0, R(0, 1)));
    step(V("rr_done",  0, 0, 0, 0, 0, 0, 0, 0, D()));
    step(V("rr_idle",  0, 0, 0, 0, 0, 0, 0, 0, Z));

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
